// File: rtl/amba_initiator.sv
// APB-style bus initiator: queues read/write commands in a small FIFO and
// issues one PENABLE transaction per command, with a PREADY timeout.
//
// Ports:
//   PCLK, PRESET          clock, async active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_write/addr/wdata   command push side
//   o_rsp_valid/write/rdata/error                     one-cycle response
//   o_busy                FIFO non-empty or transaction in progress
//   PENABLE/PnR_W/PADDR/PWDATA/PREADY/PRDATA           target bus
module amba_initiator #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic                  i_cmd_write,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
   output logic                  o_rsp_valid,
   output logic                  o_rsp_write,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_error,
   output logic                  o_busy,
   output logic                  PENABLE,
   output logic                  PnR_W,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_e;

   state_e                state_q, state_d;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  penable_q, penable_d;
   logic                  pnrw_q, pnrw_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_write_q, rsp_write_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_error_q, rsp_error_d;
   logic                  push, pop;
   logic [EW-1:0]         head;

   assign o_cmd_ready = (cnt_q != FULL);
   assign push        = i_cmd_valid & o_cmd_ready;
   assign pop         = (state_q == IDLE) & (cnt_q != '0);
   assign head        = mem_q[rd_ptr_q];

   always_ff @(posedge PCLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {i_cmd_write, i_cmd_addr, i_cmd_wdata};
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      penable_d   = penable_q;
      pnrw_d      = pnrw_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               {pnrw_d, paddr_d, pwdata_d} = head;
               penable_d = 1'b1;
               timer_d   = '0;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            // PREADY takes priority over an expiring timer.
            if (PREADY) begin
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = pnrw_q;
               rsp_rdata_d = pnrw_q ? '0 : PRDATA;
               rsp_error_d = 1'b0;
               state_d     = GAP;
            end else if (timer_q == TMAX) begin
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = pnrw_q;
               rsp_rdata_d = '0;
               rsp_error_d = 1'b1;
               state_d     = GAP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         timer_q     <= '0;
         penable_q   <= 1'b0;
         pnrw_q      <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         penable_q   <= penable_d;
         pnrw_q      <= pnrw_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign PENABLE     = penable_q;
   assign PnR_W       = pnrw_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_write = rsp_write_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_error = rsp_error_q;
   assign o_busy      = (cnt_q != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_amba_initiator.sv
// Directed bench for amba_initiator with a small 4-byte target model.
// Target raises PREADY 4 cycles after PENABLE rises unless stalled.
module tb_amba_initiator;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       i_cmd_valid, i_cmd_write;
   logic [1:0] i_cmd_addr;
   logic [7:0] i_cmd_wdata;
   logic       o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_error, o_busy;
   logic [7:0] o_rsp_rdata;
   logic       PENABLE, PnR_W, PREADY;
   logic [1:0] PADDR;
   logic [7:0] PWDATA, PRDATA;

   always #5 PCLK = ~PCLK;

   amba_initiator dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr),
      .i_cmd_wdata(i_cmd_wdata),
      .o_rsp_valid(o_rsp_valid), .o_rsp_write(o_rsp_write),
      .o_rsp_rdata(o_rsp_rdata), .o_rsp_error(o_rsp_error),
      .o_busy(o_busy),
      .PENABLE(PENABLE), .PnR_W(PnR_W), .PADDR(PADDR),
      .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
   );

   // ---------------- target model ----------------
   localparam int TGT_DLY = 4;
   logic [7:0] tmem [4];
   logic       tgt_rdy;
   logic       tgt_stall = 1'b0;
   logic       spur = 1'b0;
   int         tcnt;

   assign PREADY = tgt_rdy | spur;

   always @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         tmem[0] <= 8'h01; tmem[1] <= 8'h02;
         tmem[2] <= 8'h03; tmem[3] <= 8'h04;
         tgt_rdy <= 1'b0;
         tcnt    <= 0;
         PRDATA  <= 8'h00;
      end else begin
         tgt_rdy <= 1'b0;
         if (PENABLE && !tgt_rdy && !tgt_stall) begin
            if (tcnt == TGT_DLY - 1) begin
               tgt_rdy <= 1'b1;
               tcnt    <= 0;
               if (PnR_W) tmem[PADDR] <= PWDATA;
               else       PRDATA <= tmem[PADDR];
            end else begin
               tcnt <= tcnt + 1;
            end
         end else begin
            tcnt <= 0;
         end
      end
   end

   // ---------------- bus monitor ----------------
   typedef struct {logic w; logic [7:0] rd; logic err; int cyc;} rsp_t;
   typedef struct {logic w; logic [1:0] a; logic [7:0] d; int cyc;} rise_t;
   rsp_t  rsp_q[$];
   rise_t rise_q[$];
   int    fall_q[$];
   int    cyc = 0;
   int    unstable = 0;
   logic  pen_prev = 1'b0;
   logic [10:0] held = '0;

   always @(negedge PCLK) begin
      cyc++;
      if (o_rsp_valid)
         rsp_q.push_back('{o_rsp_write, o_rsp_rdata, o_rsp_error, cyc});
      if (PENABLE && !pen_prev)
         rise_q.push_back('{PnR_W, PADDR, PWDATA, cyc});
      if (!PENABLE && pen_prev)
         fall_q.push_back(cyc);
      if (PENABLE && pen_prev && ({PnR_W, PADDR, PWDATA} != held))
         unstable++;
      held     = {PnR_W, PADDR, PWDATA};
      pen_prev = PENABLE;
   end

   // ---------------- checking helpers ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge PCLK);
      #1;
   endtask

   task automatic push(input logic w, input logic [1:0] a,
                       input logic [7:0] d, output logic acc);
      i_cmd_valid = 1'b1;
      i_cmd_write = w;
      i_cmd_addr  = a;
      i_cmd_wdata = d;
      acc = o_cmd_ready;
      step();
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(int n, int maxc, string tag);
      int i = 0;
      while (rsp_q.size() < n && i < maxc) begin
         step();
         i++;
      end
      chk(tag, 32'(rsp_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(string tag);
      int i = 0;
      while (o_busy && i < 100) begin
         step();
         i++;
      end
      chk(tag, 32'(o_busy), 32'd0);
      step();
   endtask

   // ---------------- directed sequence ----------------
   logic         acc;
   logic         accs [6];
   int           sb, rb, fb;
   logic [7:0]   exp_rd [5];

   initial begin
      PRESET      = 1'b0;
      i_cmd_valid = 1'b0;
      i_cmd_write = 1'b0;
      i_cmd_addr  = '0;
      i_cmd_wdata = '0;
      step();
      step();
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_pnrw",    32'(PnR_W), 32'd0);
      chk("rst_paddr",   32'(PADDR), 32'd0);
      chk("rst_pwdata",  32'(PWDATA), 32'd0);
      chk("rst_rsp_vld", 32'(o_rsp_valid), 32'd0);
      chk("rst_rsp_dat", 32'({o_rsp_write, o_rsp_rdata, o_rsp_error}), 32'd0);
      chk("rst_busy",    32'(o_busy), 32'd0);
      chk("rst_ready",   32'(o_cmd_ready), 32'd1);
      PRESET = 1'b1;
      step();

      // write A5 to addr 2, then read it back
      sb = rsp_q.size(); rb = rise_q.size(); fb = fall_q.size();
      push(1'b1, 2'd2, 8'hA5, acc);
      push(1'b0, 2'd2, 8'h00, acc);
      wait_rsp(sb + 2, 60, "wr_rd_done");
      chk("wr_rsp_write", 32'(rsp_q[sb].w), 32'd1);
      chk("wr_rsp_rdata", 32'(rsp_q[sb].rd), 32'h00);
      chk("wr_rsp_error", 32'(rsp_q[sb].err), 32'd0);
      chk("rd_rsp_write", 32'(rsp_q[sb+1].w), 32'd0);
      chk("rd_rsp_rdata", 32'(rsp_q[sb+1].rd), 32'hA5);
      chk("rd_rsp_error", 32'(rsp_q[sb+1].err), 32'd0);
      chk("wr_pnrw",      32'(rise_q[rb].w), 32'd1);
      chk("wr_paddr",     32'(rise_q[rb].a), 32'd2);
      chk("wr_pwdata",    32'(rise_q[rb].d), 32'hA5);
      chk("rd_pnrw",      32'(rise_q[rb+1].w), 32'd0);
      chk("wr_high_len",  32'(fall_q[fb] - rise_q[rb].cyc), 32'd5);
      chk("b2b_low_gap",  32'(rise_q[rb+1].cyc - fall_q[fb]), 32'd2);
      chk("rsp_at_fall",  32'(rsp_q[sb].cyc - fall_q[fb]), 32'd0);
      wait_idle("idle_1");

      // timeout on a stalled read, then a queued write still runs
      tgt_stall = 1'b1;
      sb = rsp_q.size(); rb = rise_q.size(); fb = fall_q.size();
      push(1'b0, 2'd1, 8'h00, acc);
      push(1'b1, 2'd3, 8'h5A, acc);
      wait_rsp(sb + 1, 40, "to_done");
      tgt_stall = 1'b0;
      chk("to_high_len", 32'(fall_q[fb] - rise_q[rb].cyc), 32'd16);
      chk("to_error",    32'(rsp_q[sb].err), 32'd1);
      chk("to_rdata",    32'(rsp_q[sb].rd), 32'h00);
      chk("to_write",    32'(rsp_q[sb].w), 32'd0);
      wait_rsp(sb + 2, 40, "to_next_done");
      chk("to_next_addr",  32'(rise_q[rb+1].a), 32'd3);
      chk("to_next_write", 32'(rsp_q[sb+1].w), 32'd1);
      chk("to_next_error", 32'(rsp_q[sb+1].err), 32'd0);
      wait_idle("idle_2");

      // FIFO full behind a stalled target
      tgt_stall = 1'b1;
      sb = rsp_q.size(); rb = rise_q.size();
      for (int i = 0; i < 6; i++) begin
         push(1'b0, 2'(i), 8'h00, acc);
         accs[i] = acc;
      end
      for (int i = 0; i < 5; i++)
         chk($sformatf("full_acc%0d", i), 32'(accs[i]), 32'd1);
      chk("full_acc5",   32'(accs[5]), 32'd0);
      chk("full_ready",  32'(o_cmd_ready), 32'd0);
      chk("full_busy",   32'(o_busy), 32'd1);
      tgt_stall = 1'b0;
      wait_rsp(sb + 5, 200, "full_done");
      exp_rd[0] = 8'h01; exp_rd[1] = 8'h02; exp_rd[2] = 8'hA5;
      exp_rd[3] = 8'h5A; exp_rd[4] = 8'h01;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("full_addr%0d", i), 32'(rise_q[rb+i].a), 32'(i % 4));
         chk($sformatf("full_rd%0d", i), 32'(rsp_q[sb+i].rd), 32'(exp_rd[i]));
         chk($sformatf("full_err%0d", i), 32'(rsp_q[sb+i].err), 32'd0);
      end
      repeat (20) step();
      chk("full_rsp_cnt", 32'(rsp_q.size() - sb), 32'd5);
      chk("full_idle",    32'(o_busy), 32'd0);
      step();

      // spurious PREADY in IDLE
      sb = rsp_q.size();
      spur = 1'b1;
      step();
      spur = 1'b0;
      chk("spur_idle_vld", 32'(o_rsp_valid), 32'd0);
      chk("spur_idle_pen", 32'(PENABLE), 32'd0);
      chk("spur_idle_bsy", 32'(o_busy), 32'd0);
      step();
      chk("spur_idle_cnt", 32'(rsp_q.size() - sb), 32'd0);

      // spurious PREADY in GAP
      push(1'b1, 2'd0, 8'h33, acc);
      wait_rsp(sb + 1, 40, "spur_gap_done");
      spur = 1'b1;
      step();
      spur = 1'b0;
      chk("spur_gap_vld", 32'(o_rsp_valid), 32'd0);
      chk("spur_gap_bsy", 32'(o_busy), 32'd0);
      step();
      chk("spur_gap_cnt", 32'(rsp_q.size() - sb), 32'd1);

      // async reset in the middle of a read
      sb = rsp_q.size();
      push(1'b0, 2'd1, 8'h00, acc);
      for (int i = 0; i < 10 && !PENABLE; i++) step();
      chk("mid_pen_up", 32'(PENABLE), 32'd1);
      step();
      #2;
      PRESET = 1'b0;
      #1;
      chk("mid_rst_pen",   32'(PENABLE), 32'd0);
      chk("mid_rst_busy",  32'(o_busy), 32'd0);
      chk("mid_rst_ready", 32'(o_cmd_ready), 32'd1);
      step();
      step();
      PRESET = 1'b1;
      step();
      step();
      chk("mid_rst_norsp", 32'(rsp_q.size() - sb), 32'd0);
      push(1'b0, 2'd0, 8'h00, acc);
      wait_rsp(sb + 1, 40, "post_rst_done");
      chk("post_rst_rd",  32'(rsp_q[sb].rd), 32'h01);
      chk("post_rst_err", 32'(rsp_q[sb].err), 32'd0);
      chk("post_rst_w",   32'(rsp_q[sb].w), 32'd0);
      wait_idle("idle_end");

      chk("bus_stable", 32'(unstable), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/amba_initiator.md
# amba_initiator

APB-style bus initiator that drives the 8-bit CPU-memory target used by the Zigbee Tx/Rx interfaces. It accepts read/write commands from the Zigbee datapath through a small command FIFO and issues one bus transaction per command on PENABLE/PnR_W/PADDR/PWDATA. It waits for PREADY, returns read data and status on a response port, and aborts hung transfers with a timeout.

## Interface
- DATA_WIDTH, 8, PWDATA/PRDATA/command data width
- ADDR_WIDTH, 2, PADDR/command address width
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY (≥2)

Ports (one clock; reset is asynchronous and active-low):
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  FIFO not full (combinational from FIFO count)
- i_cmd_write  in  1  1=write, 0=read
- i_cmd_addr  in  ADDR_WIDTH  target address
- i_cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- o_rsp_valid  out  1  one-cycle response pulse, no backpressure
- o_rsp_write  out  1  type of completed command
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- o_rsp_error  out  1  transaction timed out
- o_busy  out  1  FIFO non-empty or FSM not IDLE
- PENABLE  out  1  transaction request, level, registered
- PnR_W  out  1  0=read, 1=write, registered
- PADDR  out  ADDR_WIDTH  registered
- PWDATA  out  DATA_WIDTH  registered
- PREADY  in  1  target completion, one-cycle pulse
- PRDATA  in  DATA_WIDTH  target read data, valid when PREADY=1

## Operation
- Command FIFO: push on i_cmd_valid & o_cmd_ready; pop only in IDLE when non-empty; pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH. When full, o_cmd_ready=0 and offers are not stored. Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, ACCESS, GAP.
  - IDLE: if FIFO non-empty, pop the head, register PnR_W/PADDR/PWDATA from it, set PENABLE<=1, clear the timer, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: PENABLE, PnR_W, PADDR and PWDATA are held stable. On PREADY=1: PENABLE<=0, o_rsp_valid<=1, o_rsp_write<=PnR_W, o_rsp_rdata<=(read ? PRDATA : 0), o_rsp_error<=0, go to GAP. If the timer reaches TIMEOUT-1 without PREADY: PENABLE<=0, o_rsp_valid<=1, o_rsp_error<=1, o_rsp_rdata<=0, go to GAP. PREADY wins if both conditions occur in the same cycle.
  - GAP: one cycle with PENABLE=0, so the target sees a fresh rising edge on the next transaction. Go to IDLE.
- PREADY outside ACCESS is ignored and produces no response.
- Reads use PnR_W=0; writes use PnR_W=1. PWDATA is don't-care for reads but is still driven from the FIFO entry.
- Reset (asynchronous assert): FSM to IDLE, FIFO flushed. PENABLE, PnR_W, PADDR, PWDATA, o_rsp_valid, o_rsp_write, o_rsp_rdata, o_rsp_error all 0. o_busy=0, o_cmd_ready=1. A transaction in flight is dropped with no response.

## Timing
- Command accepted at edge E0 with FSM in IDLE and FIFO empty: PENABLE=1 after E1.
- PREADY sampled high at edge Ek: o_rsp_valid=1 for exactly the cycle after Ek, and PENABLE=0 after Ek.
- Back-to-back commands: PENABLE is low for exactly 2 cycles between transactions (the ACCESS exit edge plus GAP, then IDLE reasserts at the next edge).
- Timeout: PENABLE falls at most TIMEOUT cycles after it rose.
- Single-transaction throughput: 1 cycle IDLE + ACCESS duration + 1 cycle GAP.

## Test plan
- Write then read, target with PREADY 4 cycles after PENABLE rise: cmd write addr 2 data 0xA5, then read addr 2 -> write response (rsp_write=1, rdata=0x00, error=0); read response rdata=0xA5; PnR_W=1 then 0 observed; PENABLE low for 2 cycles between the transactions.
- Timeout, TIMEOUT=16, PREADY held 0: read addr 1 -> PENABLE high exactly 16 cycles, then one rsp_valid with error=1, rdata=0x00; the next queued command still executes.
- FIFO full, stalled target: offer 6 commands back-to-back -> the first pops immediately, then 4 fill the FIFO, o_cmd_ready=0 with the 6th offer not accepted; all 5 accepted commands complete in order with addresses 0,1,2,3,0.
- Spurious PREADY in IDLE and GAP: pulse PREADY with no command -> no rsp_valid; FSM stays IDLE.
- Reset mid-ACCESS: assert PRESET low asynchronously between edges during a read -> PENABLE=0 immediately, o_busy=0, o_cmd_ready=1, no response; after release, a fresh read of addr 0 returns the target's value (0x01 after target reset).
